// File: rtl/dualmem_port_arbiter_if.sv
// Requester-side handshake and RAM-port bundle for dualmem_port_arbiter.
// The arbiter uses the slave modport; the requester/RAM side uses master.
interface dualmem_port_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
);
  localparam int BEW = DATA_WIDTH / 8;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*BEW-1:0]        req_we;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_lock;
  logic [NREQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       mem_en;
  logic [BEW-1:0]             mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dualmem_port_arbiter.sv
// Round-robin arbiter with lock sharing one RAM port among NREQ requesters.
// Grant and RAM drive are combinational; responses follow acceptance by one cycle.
module dualmem_port_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  dualmem_port_arbiter_if.slave bus
);
  localparam int BEW = DATA_WIDTH / 8;
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return wrap_add(v, 1);
  endfunction

  logic [PW-1:0]   prio;
  logic            locked;
  logic [PW-1:0]   lock_owner;
  logic [NREQ-1:0] rsp_vec_p1;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] accept;

  // Stage p0: priority scan from prio, or owner-only while locked.
  always_comb begin
    logic [PW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (locked) begin
      if (bus.req_valid[lock_owner]) begin
        gnt_found = 1'b1;
        gnt_idx   = lock_owner;
      end
    end else begin
      // Scanning from the far end lets the nearest valid requester win last.
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = wrap_add(prio, k);
        if (bus.req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (!rstn) gnt_found = 1'b0;
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < NREQ; i++) begin
      accept[i] = gnt_found && (gnt_idx == PW'(i));
    end
  end

  assign bus.req_ready = accept;
  assign bus.mem_en    = gnt_found;
  assign bus.mem_we    = gnt_found ? bus.req_we[gnt_idx*BEW +: BEW] : '0;
  assign bus.mem_addr  = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_wdata = bus.req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  // Stage p1: arbitration state update and one-hot response capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio       <= '0;
      locked     <= 1'b0;
      lock_owner <= '0;
      rsp_vec_p1 <= '0;
    end else begin
      rsp_vec_p1 <= accept;
      if (gnt_found) begin
        prio       <= wrap_inc(gnt_idx);
        locked     <= bus.req_lock[gnt_idx];
        lock_owner <= gnt_idx;
      end
    end
  end

  assign bus.rsp_valid = rsp_vec_p1;
  assign bus.rsp_rdata = bus.mem_rdata;
endmodule
